// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Inter-stage pipeline register with a valid/ready handshake and a
//   2-entry skid buffer (main + skid). ready_out is registered and is low
//   only while both entries hold data. A synchronous flush empties the
//   stage and zeroes the control field, so no write enable survives it.
//   The control field reads 0 whenever the stage holds a bubble.
//   A taken branch clears bit 0 of the target address as it is captured.
//   Optional feature macro: PIPE_STAGE_PERF_CNT_EN adds saturating
//   stall/flush cycle counters (stall_cnt_out, flush_cnt_out).
module pipe_stage_skid_reg #(
    parameter int PAYLOAD_W = 128,
    parameter int CTRL_W    = 12,
    parameter int ADDR_W    = 32
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 flush_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic                 branch_taken_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [ADDR_W-1:0]    addr_out
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt_out,
    output logic [CNT_W-1:0]     flush_cnt_out
`endif
);

    // EMPTY: main invalid; BUSY: main valid, skid empty; FULL: both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                 ready_reg;
    logic [PAYLOAD_W-1:0] main_payload_reg, skid_payload_reg;
    logic [CTRL_W-1:0]    main_ctrl_reg,    skid_ctrl_reg;
    logic [ADDR_W-1:0]    main_addr_reg,    skid_addr_reg;

    logic                 in_fire;
    logic                 out_fire;
    logic [ADDR_W-1:0]    cap_addr;

    // datapath steering decided by the FSM
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;
    logic                 clear_main_ctrl;
    logic                 clear_skid_ctrl;

    assign in_fire  = valid_in & ready_reg;
    assign out_fire = (state_reg != EMPTY) & ready_in;
    assign cap_addr = {addr_in[ADDR_W-1:1], addr_in[0] & ~branch_taken_in};

    // State register and registered ready (ready = skid empty next cycle)
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != FULL);
        end
    end

    // Next-state and datapath steering; flush overrides every transition
    always_comb begin
        state_next      = state_reg;
        load_main_in    = 1'b0;
        load_main_skid  = 1'b0;
        load_skid       = 1'b0;
        clear_main_ctrl = 1'b0;
        clear_skid_ctrl = 1'b0;
        if (flush_in) begin
            state_next      = EMPTY;
            clear_main_ctrl = 1'b1;
            clear_skid_ctrl = 1'b1;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_next   = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && ready_in) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (out_fire) begin
                        // going empty: zero control so the bubble carries no enables
                        clear_main_ctrl = 1'b1;
                        state_next      = EMPTY;
                    end
                end
                FULL: begin
                    // ready_out is low here, so nothing new can be captured
                    if (ready_in) begin
                        load_main_skid = 1'b1;
                        state_next     = BUSY;
                    end
                end
                default: begin
                    clear_main_ctrl = 1'b1;
                    clear_skid_ctrl = 1'b1;
                    state_next      = EMPTY;
                end
            endcase
        end
    end

    // Main (output) entry; payload/addr hold when the stage empties
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            main_payload_reg <= '0;
            main_ctrl_reg    <= '0;
            main_addr_reg    <= '0;
        end else if (load_main_in) begin
            main_payload_reg <= payload_in;
            main_ctrl_reg    <= ctrl_in;
            main_addr_reg    <= cap_addr;
        end else if (load_main_skid) begin
            main_payload_reg <= skid_payload_reg;
            main_ctrl_reg    <= skid_ctrl_reg;
            main_addr_reg    <= skid_addr_reg;
        end else if (clear_main_ctrl) begin
            main_ctrl_reg    <= '0;
        end
    end

    // Skid entry; catches the input taken while downstream stalls
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            skid_payload_reg <= '0;
            skid_ctrl_reg    <= '0;
            skid_addr_reg    <= '0;
        end else if (load_skid) begin
            skid_payload_reg <= payload_in;
            skid_ctrl_reg    <= ctrl_in;
            skid_addr_reg    <= cap_addr;
        end else if (clear_skid_ctrl) begin
            skid_ctrl_reg    <= '0;
        end
    end

    assign ready_out   = ready_reg;
    assign valid_out   = (state_reg != EMPTY);
    assign payload_out = main_payload_reg;
    assign ctrl_out    = main_ctrl_reg;
    assign addr_out    = main_addr_reg;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Saturating perf counters; only reset clears them, flush does not
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (valid_out && !ready_in && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_in && (flush_cnt_reg != {CNT_W{1'b1}}))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt_out = stall_cnt_reg;
    assign flush_cnt_out = flush_cnt_reg;
`endif

endmodule
